vga_plot_arbiter: RTL and testbench

//  Shares the single VGA adapter pixel-write port (VGA_X/VGA_Y/VGA_COLOR/plot) between two

---
 rtl/vga_plot_arbiter_pkg.sv | 25 ++
 rtl/vga_plot_arbiter_if.sv | 35 +++
 rtl/vga_plot_arbiter_rr_arb2.sv | 30 +++
 rtl/vga_plot_arbiter.sv | 133 +++++++++++++
 tb/tb_vga_plot_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared types and resolution helpers for the VGA pixel-write arbiter.
// Maps the adapter resolution string onto coordinate widths and raster limits.
package vga_plot_arbiter_pkg;

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  function automatic int xw_of(input string res);
    if (res == "640x480") return 10;
    else if (res == "320x240") return 9;
    else return 8;
  endfunction

  function automatic int xmax_of(input string res);
    if (res == "640x480") return 639;
    else if (res == "320x240") return 319;
    else return 159;
  endfunction

  function automatic int ymax_of(input string res);
    if (res == "640x480") return 479;
    else if (res == "320x240") return 239;
    else return 119;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester handshakes plus the registered pixel-write port toward the vga_adapter.
interface vga_plot_arbiter_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CD = 9
);
  logic          clear_req;
  logic [CD-1:0] clear_color;
  logic          a_valid, a_ready;
  logic [XW-1:0] a_x;
  logic [YW-1:0] a_y;
  logic [CD-1:0] a_color;
  logic          b_valid, b_ready;
  logic [XW-1:0] b_x;
  logic [YW-1:0] b_y;
  logic [CD-1:0] b_color;
  logic [XW-1:0] VGA_X;
  logic [YW-1:0] VGA_Y;
  logic [CD-1:0] VGA_COLOR;
  logic          plot, busy, clear_done, oob_err;

  modport slave (
    input  clear_req, clear_color,
    input  a_valid, a_x, a_y, a_color, b_valid, b_x, b_y, b_color,
    output a_ready, b_ready,
    output VGA_X, VGA_Y, VGA_COLOR, plot, busy, clear_done, oob_err
  );

  modport master (
    output clear_req, clear_color,
    output a_valid, a_x, a_y, a_color, b_valid, b_x, b_y, b_color,
    input  a_ready, b_ready,
    input  VGA_X, VGA_Y, VGA_COLOR, plot, busy, clear_done, oob_err
  );
endinterface

// File: rtl/vga_plot_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer always moves to the side not just granted.
module rr_arb2 (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  // ptr_q: 0 = requester A owns the tie, 1 = requester B
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the adapter pixel port between two requesters and a full-screen clear sweep.
// At most one pixel per cycle; all adapter-facing outputs are registered.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter string RESOLUTION  = "160x120",
  parameter int    COLOR_DEPTH = 9
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  vga_plot_arbiter_if.slave  bus
);
  localparam int XW    = xw_of(RESOLUTION);
  localparam int YW    = XW - 1;
  localparam int CD    = COLOR_DEPTH;
  localparam logic [XW-1:0] XL = XW'(xmax_of(RESOLUTION));
  localparam logic [YW-1:0] YL = YW'(ymax_of(RESOLUTION));

  state_e        state_q, state_d;
  logic [XW-1:0] cx_q, cx_d, vx_q, vx_d, sel_x;
  logic [YW-1:0] cy_q, cy_d, vy_q, vy_d, sel_y;
  logic [CD-1:0] col_q, col_d, vc_q, vc_d, sel_c;
  logic          plot_q, plot_d, busy_q, done_q, done_d, oob_q, oob_d;
  logic          arb_en, sel_oob;
  logic [1:0]    gnt;

  // clear_req outranks both requesters while idle
  assign arb_en = (state_q == S_IDLE) && !bus.clear_req;

  rr_arb2 u_arb (
    .gclk   (CLOCK_50),
    .grst_n (resetn),
    .en_i   (arb_en),
    .req_i  ({bus.b_valid, bus.a_valid}),
    .gnt_o  (gnt)
  );

  assign bus.a_ready = gnt[0];
  assign bus.b_ready = gnt[1];

  assign sel_x   = gnt[1] ? bus.b_x     : bus.a_x;
  assign sel_y   = gnt[1] ? bus.b_y     : bus.a_y;
  assign sel_c   = gnt[1] ? bus.b_color : bus.a_color;
  assign sel_oob = (sel_x > XL) || (sel_y > YL);

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    col_d   = col_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    plot_d  = 1'b0;
    done_d  = 1'b0;
    oob_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.clear_req) begin
          state_d = S_CLEAR;
          cx_d    = '0;
          cy_d    = '0;
          col_d   = bus.clear_color;
        end else if (|gnt) begin
          // out-of-range pixels are consumed but never reach the adapter
          if (sel_oob) begin
            oob_d = 1'b1;
          end else begin
            vx_d   = sel_x;
            vy_d   = sel_y;
            vc_d   = sel_c;
            plot_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        vx_d   = cx_q;
        vy_d   = cy_q;
        vc_d   = col_q;
        plot_d = 1'b1;
        if (cx_q == XL) begin
          cx_d = '0;
          if (cy_q == YL) begin
            cy_d    = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      col_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      col_q   <= col_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
      busy_q  <= (state_d == S_CLEAR);
      done_q  <= done_d;
      oob_q   <= oob_d;
    end
  end

  assign bus.VGA_X      = vx_q;
  assign bus.VGA_Y      = vy_q;
  assign bus.VGA_COLOR  = vc_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.clear_done = done_q;
  assign bus.oob_err    = oob_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench: stimulus pushes expected plots, a negedge monitor pops and compares.
module tb_vga_plot_arbiter;
  localparam int NPIX = 160 * 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_plot_arbiter_if #(.XW(8), .YW(7), .CD(9)) bus();

  vga_plot_arbiter #(.RESOLUTION("160x120"), .COLOR_DEPTH(9)) dut (
    .CLOCK_50 (clk),
    .resetn   (rst_n),
    .bus      (bus)
  );

  exp_t q[$];
  int   oob_exp = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_pix(input int x, input int y, input int c, input logic d);
    exp_t e;
    e.x = 8'(x); e.y = 7'(y); e.c = 9'(c); e.done = d;
    q.push_back(e);
  endfunction

  function automatic void push_sweep(input int c);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        push_pix(x, y, c, (x == 159) && (y == 119));
  endfunction

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.plot) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d expected no plot", bus.VGA_X, bus.VGA_Y);
      end else begin
        e = q.pop_front();
        check("plot_pixel", 32'({bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, bus.clear_done}), 32'(e));
      end
    end else if (bus.clear_done) begin
      check("done_without_plot", 32'(bus.clear_done), 32'd0);
    end
    if (bus.oob_err) begin
      check("oob_expected", 32'(bus.oob_err), (oob_exp > 0) ? 32'd1 : 32'd0);
      check("oob_plot", 32'(bus.plot), 32'd0);
      if (oob_exp > 0) oob_exp--;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.clear_req = 0; bus.clear_color = '0;
    bus.a_valid = 0; bus.a_x = '0; bus.a_y = '0; bus.a_color = '0;
    bus.b_valid = 0; bus.b_x = '0; bus.b_y = '0; bus.b_color = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_idle", 32'({bus.plot, bus.busy, bus.a_ready, bus.b_ready, bus.clear_done, bus.oob_err}), 32'd0);
    end
    check("reset_vga", 32'({bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR}), 32'd0);

    // 3: both valid, alternate A,B,A,B
    bus.a_valid = 1; bus.a_x = 8'd1; bus.a_y = 7'd2; bus.a_color = 9'h011;
    bus.b_valid = 1; bus.b_x = 8'd3; bus.b_y = 7'd4; bus.b_color = 9'h022;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready", 32'({bus.a_ready, bus.b_ready}), (i % 2 == 0) ? 32'b10 : 32'b01);
      if (i % 2 == 0) push_pix(1, 2, 9'h011, 1'b0);
      else            push_pix(3, 4, 9'h022, 1'b0);
      tick();
    end
    bus.a_valid = 0; bus.b_valid = 0;
    tick();

    // 4: only B
    bus.b_valid = 1; bus.b_x = 8'd10; bus.b_y = 7'd20; bus.b_color = 9'h0F0;
    #1;
    check("b_only_ready", 32'({bus.a_ready, bus.b_ready}), 32'b01);
    push_pix(10, 20, 9'h0F0, 1'b0);
    tick();
    bus.b_valid = 0;
    check("b_only_out", 32'({bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR}), {7'd0, 1'b1, 8'd10, 7'd20, 9'h0F0});
    tick();

    // 2: full clear sweep
    bus.clear_color = 9'h1FF; bus.clear_req = 1;
    push_sweep(9'h1FF);
    @(posedge clk); #1;
    bus.clear_req = 0;
    tick();
    check("clear_busy", 32'(bus.busy), 32'd1);
    repeat (NPIX - 1) tick();
    check("clear_last", 32'({bus.plot, bus.clear_done, bus.VGA_X, bus.VGA_Y}), {15'd0, 1'b1, 1'b1, 8'd159, 7'd119});
    tick();
    check("clear_end", 32'({bus.busy, bus.plot, bus.clear_done}), 32'd0);

    // 5: clear_req beats a_valid; mid-sweep clear_req ignored; A served after sweep
    bus.a_valid = 1; bus.a_x = 8'd5; bus.a_y = 7'd6; bus.a_color = 9'h00A;
    bus.clear_color = 9'h055; bus.clear_req = 1;
    #1;
    check("clear_prio_ready", 32'(bus.a_ready), 32'd0);
    push_sweep(9'h055);
    push_pix(5, 6, 9'h00A, 1'b0);
    @(posedge clk); #1;
    bus.clear_req = 0;
    tick();
    check("sweep_ready", 32'({bus.a_ready, bus.busy}), 32'b01);
    repeat (99) tick();
    bus.clear_color = 9'h1AA; bus.clear_req = 1;
    #1;
    check("mid_sweep_ready", 32'(bus.a_ready), 32'd0);
    tick();
    bus.clear_req = 0;
    repeat (NPIX - 101) tick();
    check("sweep5_done", 32'({bus.clear_done, bus.a_ready}), 32'b11);
    tick();
    bus.a_valid = 0;
    check("a_after_sweep", 32'({bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR}), {7'd0, 1'b1, 8'd5, 7'd6, 9'h00A});
    tick();

    // 6: out-of-range x then y
    bus.a_valid = 1; bus.a_x = 8'd160; bus.a_y = 7'd0; bus.a_color = 9'h100;
    #1;
    check("oob_x_ready", 32'(bus.a_ready), 32'd1);
    oob_exp++;
    tick();
    bus.a_x = 8'd0; bus.a_y = 7'd120;
    check("oob_x_out", 32'({bus.oob_err, bus.plot}), 32'b10);
    #1;
    check("oob_y_ready", 32'(bus.a_ready), 32'd1);
    oob_exp++;
    tick();
    bus.a_valid = 0;
    check("oob_y_out", 32'({bus.oob_err, bus.plot}), 32'b10);
    tick();
    check("oob_pulse_end", 32'(bus.oob_err), 32'd0);

    // 6: reset mid-sweep at pixel 5000
    bus.clear_color = 9'h1FF; bus.clear_req = 1;
    push_sweep(9'h1FF);
    @(posedge clk); #1;
    bus.clear_req = 0;
    repeat (5001) tick();
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_mid_outputs", 32'({bus.plot, bus.busy, bus.clear_done, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR}), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_idle", 32'({bus.plot, bus.busy, bus.clear_done}), 32'd0);
    end

    check("queue_drained", 32'(q.size()), 32'd0);
    check("oob_drained", 32'(oob_exp), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
